// File: rtl/ps2_mouse_cmd_sched.sv
// PS/2 mouse host command scheduler: runs the power-up init list, serves runtime
// host commands, validates ACK/BAT/ID replies with bounded retry and timeout.
module ps2_mouse_cmd_sched #(
    parameter int TIMEOUT_W = 20,
    parameter int MAX_RETRY = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       init_go,
    input  logic       host_req,
    input  logic [7:0] host_cmd,
    output logic       host_ack,
    output logic [7:0] host_resp,
    output logic       host_err,
    output logic       tx_start,
    output logic [7:0] tx_data,
    input  logic       tx_busy,
    input  logic       tx_done,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    output logic       stream_en,
    output logic       init_done,
    output logic       init_fail,
    output logic       intellimouse
);

    typedef enum logic [2:0] {
        IDLE, SEND, WAIT_TX, WAIT_ACK, WAIT_BAT1, WAIT_BAT2, WAIT_ID, DONE
    } state_t;

    localparam int RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam logic [RETRY_W-1:0] MAX_R = RETRY_W'(MAX_RETRY);

    state_t               state, state_n;
    logic [3:0]           rom_idx, rom_idx_n;
    logic [RETRY_W-1:0]   retry, retry_n;
    logic [TIMEOUT_W-1:0] tout, tout_n;
    logic                 is_init, is_init_n;
    logic [7:0]           host_byte, host_byte_n;
    logic [7:0]           id_byte, id_byte_n;
    logic                 host_hold, host_hold_n;
    logic                 host_ack_n, host_err_n, tx_start_n;
    logic [7:0]           host_resp_n, tx_data_n;
    logic                 init_done_n, init_fail_n, intellimouse_n;
    logic                 do_fail, do_resend;
    logic [7:0]           fail_resp;
    logic                 accept_init, accept_host, tout_hit, in_wait;
    logic [7:0]           cur_byte;

    function automatic logic [7:0] rom(input logic [3:0] i);
        case (i)
            4'd0:    rom = 8'hFF;
            4'd1:    rom = 8'hF3;
            4'd2:    rom = 8'hC8;
            4'd3:    rom = 8'hF3;
            4'd4:    rom = 8'h64;
            4'd5:    rom = 8'hF3;
            4'd6:    rom = 8'h50;
            4'd7:    rom = 8'hF2;
            default: rom = 8'hF4;
        endcase
    endfunction

    // host_hold blocks re-acceptance of a request whose ack was already issued
    assign accept_init = (state == IDLE) && init_go;
    assign accept_host = (state == IDLE) && !init_go && host_req && !host_hold;
    assign stream_en   = (state == IDLE) && init_done && !accept_init && !accept_host;
    assign cur_byte    = is_init ? rom(rom_idx) : host_byte;
    assign tout_hit    = &tout;
    assign in_wait     = (state == WAIT_TX) || (state == WAIT_ACK) || (state == WAIT_BAT1) ||
                         (state == WAIT_BAT2) || (state == WAIT_ID);

    always_comb begin
        state_n        = state;
        rom_idx_n      = rom_idx;
        retry_n        = retry;
        is_init_n      = is_init;
        host_byte_n    = host_byte;
        id_byte_n      = id_byte;
        host_hold_n    = host_hold && host_req;
        host_ack_n     = 1'b0;
        host_resp_n    = host_resp;
        host_err_n     = host_err;
        tx_start_n     = 1'b0;
        tx_data_n      = tx_data;
        init_done_n    = init_done;
        init_fail_n    = init_fail;
        intellimouse_n = intellimouse;
        do_fail        = 1'b0;
        do_resend      = 1'b0;
        fail_resp      = 8'h00;
        tout_n         = '0;

        case (state)
            IDLE: begin
                if (init_go) begin
                    init_done_n    = 1'b0;
                    init_fail_n    = 1'b0;
                    intellimouse_n = 1'b0;
                    rom_idx_n      = 4'd0;
                    retry_n        = '0;
                    is_init_n      = 1'b1;
                    state_n        = SEND;
                end else if (host_req && !host_hold) begin
                    host_byte_n = host_cmd;
                    retry_n     = '0;
                    is_init_n   = 1'b0;
                    state_n     = SEND;
                end
            end
            SEND: begin
                if (!tx_busy) begin
                    tx_start_n = 1'b1;
                    tx_data_n  = cur_byte;
                    state_n    = WAIT_TX;
                end
            end
            WAIT_TX: begin
                if (tx_done)       state_n = WAIT_ACK;
                else if (tout_hit) do_resend = 1'b1;
            end
            WAIT_ACK: begin
                if (rx_valid) begin
                    case (rx_data)
                        8'hFA: begin
                            if (cur_byte == 8'hFF)      state_n = WAIT_BAT1;
                            else if (cur_byte == 8'hF2) state_n = WAIT_ID;
                            else                        state_n = DONE;
                        end
                        8'hFE: begin
                            do_resend = 1'b1;
                            fail_resp = 8'hFE;
                        end
                        8'hFC: begin
                            do_fail   = 1'b1;
                            fail_resp = 8'hFC;
                        end
                        default: ;
                    endcase
                end else if (tout_hit) begin
                    do_resend = 1'b1;
                end
            end
            WAIT_BAT1, WAIT_BAT2: begin
                if (rx_valid) begin
                    if (state == WAIT_BAT1 && rx_data == 8'hAA)      state_n = WAIT_BAT2;
                    else if (state == WAIT_BAT2 && rx_data == 8'h00) state_n = DONE;
                    else begin
                        do_fail   = 1'b1;
                        fail_resp = rx_data;
                    end
                end else if (tout_hit) begin
                    do_resend = 1'b1;
                end
            end
            WAIT_ID: begin
                if (rx_valid) begin
                    id_byte_n = rx_data;
                    if (is_init) intellimouse_n = (rx_data == 8'h03);
                    state_n = DONE;
                end else if (tout_hit) begin
                    do_resend = 1'b1;
                end
            end
            DONE: begin
                retry_n = '0;
                if (is_init) begin
                    if (rom_idx < 4'd8) begin
                        rom_idx_n = rom_idx + 4'd1;
                        state_n   = SEND;
                    end else begin
                        init_done_n = 1'b1;
                        state_n     = IDLE;
                    end
                end else begin
                    host_ack_n  = 1'b1;
                    host_err_n  = 1'b0;
                    host_hold_n = 1'b1;
                    case (host_byte)
                        8'hF2:   host_resp_n = id_byte;
                        8'hFF:   host_resp_n = 8'hAA;
                        default: host_resp_n = 8'hFA;
                    endcase
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase

        if (do_resend) begin
            if (retry < MAX_R) begin
                retry_n = retry + 1'b1;
                state_n = SEND;
            end else begin
                do_fail = 1'b1;
            end
        end

        if (do_fail) begin
            retry_n = '0;
            state_n = IDLE;
            if (is_init) begin
                init_fail_n = 1'b1;
                init_done_n = 1'b0;
            end else begin
                host_ack_n  = 1'b1;
                host_err_n  = 1'b1;
                host_resp_n = fail_resp;
                host_hold_n = 1'b1;
            end
        end

        // every WAIT_* state leaves at all-ones, so the counter cannot wrap
        if (in_wait && state_n == state) tout_n = tout + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            rom_idx      <= 4'd0;
            retry        <= '0;
            tout         <= '0;
            is_init      <= 1'b0;
            host_byte    <= 8'h00;
            id_byte      <= 8'h00;
            host_hold    <= 1'b0;
            host_ack     <= 1'b0;
            host_resp    <= 8'h00;
            host_err     <= 1'b0;
            tx_start     <= 1'b0;
            tx_data      <= 8'h00;
            init_done    <= 1'b0;
            init_fail    <= 1'b0;
            intellimouse <= 1'b0;
        end else begin
            state        <= state_n;
            rom_idx      <= rom_idx_n;
            retry        <= retry_n;
            tout         <= tout_n;
            is_init      <= is_init_n;
            host_byte    <= host_byte_n;
            id_byte      <= id_byte_n;
            host_hold    <= host_hold_n;
            host_ack     <= host_ack_n;
            host_resp    <= host_resp_n;
            host_err     <= host_err_n;
            tx_start     <= tx_start_n;
            tx_data      <= tx_data_n;
            init_done    <= init_done_n;
            init_fail    <= init_fail_n;
            intellimouse <= intellimouse_n;
        end
    end

endmodule

// File: tb/tb_ps2_mouse_cmd_sched.sv
// Scoreboard bench for ps2_mouse_cmd_sched with a behavioural PS/2 mouse responder.
module tb_ps2_mouse_cmd_sched;

    localparam int TW = 6;

    logic       clk, reset, init_go, host_req;
    logic [7:0] host_cmd, host_resp, tx_data, rx_data;
    logic       host_ack, host_err, tx_start, tx_busy, tx_done, rx_valid;
    logic       stream_en, init_done, init_fail, intellimouse;

    typedef struct packed {
        logic [7:0] resp;
        logic       err;
    } ack_t;

    logic [7:0] exp_tx[$];
    ack_t       exp_ack[$];
    int         checks = 0;
    int         errors = 0;
    logic       se_at_accept;

    logic       silent_on = 1'b0, fc_on = 1'b0;
    logic [7:0] silent_byte = 8'h00, fc_byte = 8'h00, fe_byte = 8'h00, mouse_id = 8'h03;
    int         fe_left = 0;
    logic [7:0] seen_byte;

    ps2_mouse_cmd_sched #(.TIMEOUT_W(TW), .MAX_RETRY(3)) dut (
        .clk(clk), .reset(reset), .init_go(init_go), .host_req(host_req),
        .host_cmd(host_cmd), .host_ack(host_ack), .host_resp(host_resp),
        .host_err(host_err), .tx_start(tx_start), .tx_data(tx_data),
        .tx_busy(tx_busy), .tx_done(tx_done), .rx_valid(rx_valid),
        .rx_data(rx_data), .stream_en(stream_en), .init_done(init_done),
        .init_fail(init_fail), .intellimouse(intellimouse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic go, input logic req, input logic [7:0] cmd);
        @(negedge clk);
        init_go = go;
        if (req) begin
            host_req = 1'b1;
            host_cmd = cmd;
        end
        #1 se_at_accept = stream_en;
        @(negedge clk);
        init_go = 1'b0;
    endtask

    task automatic push_init_rom();
        exp_tx.push_back(8'hFF); exp_tx.push_back(8'hF3); exp_tx.push_back(8'hC8);
        exp_tx.push_back(8'hF3); exp_tx.push_back(8'h64); exp_tx.push_back(8'hF3);
        exp_tx.push_back(8'h50); exp_tx.push_back(8'hF2); exp_tx.push_back(8'hF4);
    endtask

    task automatic wait_init_end(input int budget);
        int n = 0;
        while (!(init_done || init_fail) && n < budget) begin
            @(negedge clk);
            n++;
        end
        checkOutput("init_end_seen", {31'd0, init_done | init_fail}, 1);
    endtask

    task automatic wait_ack(input int budget);
        int n = 0;
        while (!host_ack && n < budget) begin
            @(negedge clk);
            n++;
        end
        checkOutput("host_ack_seen", {31'd0, host_ack}, 1);
        host_req = 1'b0;
    endtask

    task automatic drain();
        repeat (12) @(negedge clk);
        checkOutput("tx_queue_empty", exp_tx.size(), 0);
        checkOutput("ack_queue_empty", exp_ack.size(), 0);
    endtask

    task automatic send_rx(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic respond(input logic [7:0] b);
        if (silent_on && b == silent_byte) begin
        end else if (fc_on && b == fc_byte) begin
            send_rx(8'hFC);
        end else if (fe_left > 0 && b == fe_byte) begin
            fe_left--;
            send_rx(8'hFE);
        end else begin
            send_rx(8'hFA);
            if (b == 8'hFF) begin
                @(negedge clk);
                send_rx(8'hAA);
                @(negedge clk);
                send_rx(8'h00);
            end else if (b == 8'hF2) begin
                @(negedge clk);
                send_rx(mouse_id);
            end
        end
    endtask

    // Mouse model: shift the byte out, then reply as configured
    initial begin
        tx_busy = 1'b0; tx_done = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        forever begin
            @(negedge clk);
            if (tx_start === 1'b1 && !reset) begin
                seen_byte = tx_data;
                tx_busy = 1'b1;
                repeat (3) @(negedge clk);
                tx_done = 1'b1;
                @(negedge clk);
                tx_done = 1'b0;
                tx_busy = 1'b0;
                @(negedge clk);
                respond(seen_byte);
            end
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents a byte or an ack
    always @(negedge clk) begin
        if (!reset && tx_start === 1'b1) begin
            if (exp_tx.size() == 0) checkOutput("tx_unexpected", {24'd0, tx_data}, 32'h100);
            else                    checkOutput("tx_data", {24'd0, tx_data}, {24'd0, exp_tx.pop_front()});
        end
        if (!reset && host_ack === 1'b1) begin
            if (exp_ack.size() == 0) checkOutput("ack_unexpected", {23'd0, host_resp, host_err}, 32'h200);
            else                     checkOutput("host_ack_resp_err", {23'd0, host_resp, host_err},
                                                 {23'd0, exp_ack.pop_front()});
        end
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b1; init_go = 1'b0; host_req = 1'b0; host_cmd = 8'h00;
        repeat (3) @(negedge clk);
        checkOutput("reset_outputs",
                    {24'd0, host_ack, host_err, tx_start, stream_en, init_done, init_fail, intellimouse, 1'b0}, 0);
        reset = 1'b0;

        $display("[TB] ideal init, ID 03");
        push_init_rom();
        applyStimulus(1'b1, 1'b0, 8'h00);
        wait_init_end(3000);
        checkOutput("init_done_ideal", {31'd0, init_done}, 1);
        checkOutput("init_fail_ideal", {31'd0, init_fail}, 0);
        checkOutput("intellimouse_ideal", {31'd0, intellimouse}, 1);
        @(negedge clk);
        checkOutput("stream_en_after_init", {31'd0, stream_en}, 1);
        drain();

        $display("[TB] init with two resends of C8");
        fe_byte = 8'hC8; fe_left = 2;
        exp_tx.push_back(8'hFF); exp_tx.push_back(8'hF3);
        exp_tx.push_back(8'hC8); exp_tx.push_back(8'hC8); exp_tx.push_back(8'hC8);
        exp_tx.push_back(8'hF3); exp_tx.push_back(8'h64); exp_tx.push_back(8'hF3);
        exp_tx.push_back(8'h50); exp_tx.push_back(8'hF2); exp_tx.push_back(8'hF4);
        applyStimulus(1'b1, 1'b0, 8'h00);
        wait_init_end(3000);
        checkOutput("init_done_resend", {31'd0, init_done}, 1);
        drain();

        $display("[TB] host command E8");
        exp_tx.push_back(8'hE8);
        exp_ack.push_back('{resp: 8'hFA, err: 1'b0});
        applyStimulus(1'b0, 1'b1, 8'hE8);
        checkOutput("stream_en_at_accept", {31'd0, se_at_accept}, 0);
        wait_ack(500);
        @(negedge clk);
        checkOutput("stream_en_after_host", {31'd0, stream_en}, 1);
        drain();

        $display("[TB] init_go and host_req together");
        push_init_rom();
        exp_tx.push_back(8'hF2);
        exp_ack.push_back('{resp: 8'h03, err: 1'b0});
        applyStimulus(1'b1, 1'b1, 8'hF2);
        wait_init_end(3000);
        checkOutput("init_done_before_host", {31'd0, init_done}, 1);
        wait_ack(500);
        checkOutput("ack_after_init", {31'd0, init_done}, 1);
        checkOutput("intellimouse_kept", {31'd0, intellimouse}, 1);
        drain();

        $display("[TB] silent after F3");
        silent_on = 1'b1; silent_byte = 8'hF3;
        exp_tx.push_back(8'hFF);
        repeat (4) exp_tx.push_back(8'hF3);
        applyStimulus(1'b1, 1'b0, 8'h00);
        wait_init_end(5000);
        checkOutput("init_fail_silent", {31'd0, init_fail}, 1);
        checkOutput("init_done_silent", {31'd0, init_done}, 0);
        checkOutput("stream_en_silent", {31'd0, stream_en}, 0);
        silent_on = 1'b0;
        drain();

        $display("[TB] host command E6 answered with FC");
        fc_on = 1'b1; fc_byte = 8'hE6;
        exp_tx.push_back(8'hE6);
        exp_ack.push_back('{resp: 8'hFC, err: 1'b1});
        applyStimulus(1'b0, 1'b1, 8'hE6);
        wait_ack(500);
        fc_on = 1'b0;
        drain();

        $display("[TB] host command EA never answered");
        silent_on = 1'b1; silent_byte = 8'hEA;
        repeat (4) exp_tx.push_back(8'hEA);
        exp_ack.push_back('{resp: 8'h00, err: 1'b1});
        applyStimulus(1'b0, 1'b1, 8'hEA);
        wait_ack(2000);
        silent_on = 1'b0;
        drain();

        $display("[TB] reset while waiting for ACK");
        silent_on = 1'b1; silent_byte = 8'hFF;
        exp_tx.push_back(8'hFF);
        applyStimulus(1'b1, 1'b0, 8'h00);
        for (int n = 0; n < 50 && exp_tx.size() != 0; n++) @(negedge clk);
        checkOutput("first_byte_sent", exp_tx.size(), 0);
        repeat (8) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("reset_mid_outputs",
                    {8'd0, tx_data, host_resp, host_ack, host_err, tx_start, stream_en,
                     init_done, init_fail, intellimouse, 1'b0}, 0);
        reset = 1'b0;
        silent_on = 1'b0;
        @(negedge clk);
        checkOutput("no_tx_after_reset", {31'd0, tx_start}, 0);

        $display("[TB] re-init with ID 00");
        mouse_id = 8'h00;
        push_init_rom();
        applyStimulus(1'b1, 1'b0, 8'h00);
        wait_init_end(3000);
        checkOutput("init_done_reinit", {31'd0, init_done}, 1);
        checkOutput("intellimouse_reinit", {31'd0, intellimouse}, 0);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
